// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full-flag controller for an asynchronous FIFO.
// Owns the binary/Gray write pointer and derives full, almost-full, level and overflow.
module fifo_wptr_full #(
  parameter int unsigned addr_width         = 4,
  parameter int unsigned almost_full_thresh = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [addr_width:0]   wq2_rptr,
  input  logic                  wovf_clr,
  output logic                  wen,
  output logic [addr_width-1:0] waddr,
  output logic [addr_width:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [addr_width:0]   wlevel,
  output logic                  woverflow
);

  localparam int unsigned pw    = addr_width + 1;
  localparam int unsigned depth = 1 << addr_width;
  localparam logic [pw-1:0] af_level = pw'(depth - almost_full_thresh);

  logic [pw-1:0] wbin;
  logic [pw-1:0] wbin_next;
  logic [pw-1:0] wgray_next;
  logic [pw-1:0] rbin;
  logic [pw-1:0] full_ptr;
  logic [pw-1:0] level_next;

  assign waddr = wbin[addr_width-1:0];

  // Next-pointer, synchronized read pointer decode and flag terms.
  always_comb begin
    wen        = winc & ~wfull & ~rst;
    wbin_next  = wbin + pw'(wen);
    wgray_next = (wbin_next >> 1) ^ wbin_next;
    rbin       = '0;
    for (int i = 0; i < int'(pw); i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
    // Full when write pointer is one lap ahead: top two Gray bits inverted.
    full_ptr   = {~wq2_rptr[addr_width:addr_width-1], wq2_rptr[addr_width-2:0]};
    level_next = wbin_next - rbin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= (wgray_next == full_ptr);
      walmost_full <= (level_next >= af_level);
      wlevel       <= level_next;
      // A write attempt while full takes precedence over a clear.
      if (winc & wfull) begin
        woverflow <= 1'b1;
      end else if (wovf_clr) begin
        woverflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed self-checking bench for fifo_wptr_full (addr_width=4, almost_full_thresh=2).
module tb_fifo_wptr_full;

  logic       clk;
  logic       rst;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       wovf_clr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int n_cmp = 0;
  int n_err = 0;

  fifo_wptr_full #(.addr_width(4), .almost_full_thresh(2)) dut (
    .clk(clk), .rst(rst), .winc(winc), .wq2_rptr(wq2_rptr), .wovf_clr(wovf_clr),
    .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] gray(input logic [4:0] b);
    return (b >> 1) ^ b;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_wptr"},   32'(wptr), 32'd0);
    check({tag, "_waddr"},  32'(waddr), 32'd0);
    check({tag, "_wfull"},  32'(wfull), 32'd0);
    check({tag, "_walmost"}, 32'(walmost_full), 32'd0);
    check({tag, "_wlevel"}, 32'(wlevel), 32'd0);
    check({tag, "_wovf"},   32'(woverflow), 32'd0);
  endtask

  logic [4:0] exp_bin;
  logic [4:0] prev_ptr;

  initial begin
    rst = 1'b1; winc = 1'b1; wq2_rptr = 5'd0; wovf_clr = 1'b0;

    // 1. reset held with write requests pending
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rst_wen", 32'(wen), 32'd0);
      tick();
      check_all_zero("rst");
    end

    // 2. fill 16 entries with read pointer parked at 0
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("fill_wen", 32'(wen), 32'd1);
      check("fill_waddr", 32'(waddr), 32'(i));
      tick();
      exp_bin = 5'(i + 1);
      check("fill_wptr", 32'(wptr), 32'(gray(exp_bin)));
      check("fill_wlevel", 32'(wlevel), 32'(i + 1));
      check("fill_walmost", 32'(walmost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
      check("fill_wfull", 32'(wfull), (i + 1 == 16) ? 32'd1 : 32'd0);
    end
    check("fill_wptr_final", 32'(wptr), 32'h18);

    // 3. overflow while full, then set-wins and clear
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ovf_wen", 32'(wen), 32'd0);
      check("ovf_waddr", 32'(waddr), 32'd0);
      tick();
      check("ovf_wptr", 32'(wptr), 32'h18);
      check("ovf_wfull", 32'(wfull), 32'd1);
      check("ovf_flag", 32'(woverflow), 32'd1);
    end
    wovf_clr = 1'b1;
    tick();
    check("ovf_setwins", 32'(woverflow), 32'd1);
    winc = 1'b0;
    tick();
    check("ovf_clear", 32'(woverflow), 32'd0);
    check("ovf_wptr_hold", 32'(wptr), 32'h18);
    wovf_clr = 1'b0;

    // 4. drain: read side reports binary 4
    wq2_rptr = 5'b00110;
    tick();
    check("drain_wfull", 32'(wfull), 32'd0);
    check("drain_wlevel", 32'(wlevel), 32'd12);
    check("drain_walmost", 32'(walmost_full), 32'd0);
    winc = 1'b1;
    #1;
    check("drain_wen", 32'(wen), 32'd1);
    check("drain_waddr", 32'(waddr), 32'd0);
    tick();
    check("drain_wlevel2", 32'(wlevel), 32'd13);
    exp_bin = 5'd17;

    // 5. wrap through 31->0 with read pointer trailing by 3
    for (int i = 0; i < 40; i++) begin
      wq2_rptr = gray(exp_bin - 5'd3);
      prev_ptr = wptr;
      #1;
      check("wrap_wen", 32'(wen), 32'd1);
      check("wrap_waddr", 32'(waddr), 32'(exp_bin[3:0]));
      tick();
      exp_bin = exp_bin + 5'd1;
      check("wrap_wptr", 32'(wptr), 32'(gray(exp_bin)));
      check("wrap_onebit", 32'($countones(wptr ^ prev_ptr)), 32'd1);
      check("wrap_wfull", 32'(wfull), 32'd0);
      check("wrap_wlevel", 32'(wlevel), 32'd4);
      if (exp_bin == 5'd0) begin
        check("wrap_prev_31", 32'(prev_ptr), 32'h10);
        check("wrap_zero", 32'(wptr), 32'h00);
      end
    end

    // 6. reset mid-fill
    winc = 1'b0; rst = 1'b1; wq2_rptr = 5'd0;
    tick();
    rst = 1'b0; winc = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      check("mid_waddr", 32'(waddr), 32'(i));
      tick();
    end
    check("mid_wlevel_pre", 32'(wlevel), 32'd7);
    rst = 1'b1;
    #1;
    check("mid_rst_wen", 32'(wen), 32'd0);
    tick();
    check_all_zero("mid_rst");
    rst = 1'b0;
    #1;
    check("resume_wen", 32'(wen), 32'd1);
    check("resume_waddr", 32'(waddr), 32'd0);
    tick();
    check("resume_wptr", 32'(wptr), 32'd1);
    check("resume_wlevel", 32'(wlevel), 32'd1);
    check("resume_waddr1", 32'(waddr), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
